sma_window_ctrl: RTL and testbench

//  Sequencer in front of the power-of-two SMA datapath in the PIG FOG chain. Applies window-size changes

---
 rtl/sma_window_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sma_window_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sma_window_ctrl.sv
// sma_window_ctrl: sequencer in front of the power-of-two SMA datapath.
// Applies window-size changes by clearing the SMA delay RAM and sum, then
// re-primes the window and flags valid output only once the window is full.
// Forwards samples to the SMA and counts samples dropped while reconfiguring.
module sma_window_ctrl #(
  parameter int MAX_SEL = 15,
  parameter int ADDR_W  = 15,
  parameter int DROP_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_data_valid,
  input  logic [31:0]       i_data,
  input  logic [31:0]       i_window_sel,
  input  logic              i_drop_clr,
  output logic              o_update_strobe,
  output logic [31:0]       o_sma_data,
  output logic [31:0]       o_window_sel,
  output logic              o_sum_clr,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_out_valid,
  output logic [ADDR_W:0]   o_fill_cnt,
  output logic [DROP_W-1:0] o_drop_cnt,
  output logic [1:0]        o_state
);

  localparam int SEL_W = $clog2(MAX_SEL + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_FILL  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  w_sel_c;
  logic [ADDR_W:0]   w_win_n;
  logic [ADDR_W-1:0] w_last_addr;
  logic              w_change;
  logic              w_accept;
  logic              w_drop;
  logic              w_clr_done;
  logic              w_fill_done;

  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W:0]   r_fill_cnt;
  logic              r_sum_clr;
  logic              r_out_valid;
  logic              r_strobe;
  logic [31:0]       r_sma_data;
  logic [DROP_W-1:0] r_drop_cnt;

  // Clamp the requested window, derive window length and the control decisions
  always_comb begin
    w_sel_c     = (i_window_sel > 32'(MAX_SEL)) ? SEL_W'(MAX_SEL) : i_window_sel[SEL_W-1:0];
    w_win_n     = {{ADDR_W{1'b0}}, 1'b1} << r_sel;
    // For the largest window the low ADDR_W bits of N are zero, so N-1 wraps to all-ones
    w_last_addr = w_win_n[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1};
    w_change    = (r_state != S_IDLE) && (w_sel_c != r_sel);
    w_accept    = i_enable && i_data_valid && !w_change &&
                  ((r_state == S_FILL) || (r_state == S_RUN));
    w_drop      = i_enable && i_data_valid &&
                  ((r_state == S_IDLE) || (r_state == S_CLEAR) || w_change);
    w_clr_done  = (r_clr_addr == w_last_addr);
    w_fill_done = ((r_fill_cnt + 1'b1) == w_win_n);
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: disable beats window change, which beats sample handling
  always_comb begin
    w_state_next = r_state;
    if (!i_enable) begin
      w_state_next = S_IDLE;
    end else if ((r_state == S_IDLE) || w_change) begin
      w_state_next = S_CLEAR;
    end else begin
      case (r_state)
        S_CLEAR: if (w_clr_done) w_state_next = S_FILL;
        S_FILL:  if (w_accept && w_fill_done) w_state_next = S_RUN;
        default: w_state_next = r_state;
      endcase
    end
  end

  // Window bookkeeping: applied select, clear address, fill count, valid flag, sample forwarding
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel       <= '0;
      r_clr_addr  <= '0;
      r_fill_cnt  <= '0;
      r_sum_clr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_strobe    <= 1'b0;
      r_sma_data  <= '0;
    end else begin
      r_sum_clr <= 1'b0;
      r_strobe  <= w_accept;
      if (w_accept) begin
        r_sma_data <= i_data;
      end
      if (!i_enable) begin
        r_clr_addr  <= '0;
        r_fill_cnt  <= '0;
        r_out_valid <= 1'b0;
      end else if ((r_state == S_IDLE) || w_change) begin
        // (Re)start a clear with the newly applied window
        r_sel       <= w_sel_c;
        r_sum_clr   <= 1'b1;
        r_clr_addr  <= '0;
        r_fill_cnt  <= '0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          S_CLEAR: begin
            if (w_clr_done) begin
              r_clr_addr <= '0;
              r_fill_cnt <= '0;
            end else begin
              r_clr_addr <= r_clr_addr + 1'b1;
            end
          end
          S_FILL: begin
            if (w_accept) begin
              r_fill_cnt <= r_fill_cnt + 1'b1;
              if (w_fill_done) begin
                r_out_valid <= 1'b1;
              end
            end
          end
          default: begin
            r_fill_cnt <= r_fill_cnt;
          end
        endcase
      end
    end
  end

  // Saturating drop counter; a clear coinciding with a drop leaves a count of one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop_cnt <= '0;
    end else if (i_drop_clr) begin
      r_drop_cnt <= {{(DROP_W-1){1'b0}}, w_drop};
    end else if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Output mapping from state and registered values
  always_comb begin
    o_update_strobe = r_strobe;
    o_sma_data      = r_sma_data;
    o_window_sel    = {{(32-SEL_W){1'b0}}, r_sel};
    o_sum_clr       = r_sum_clr;
    o_clr_we        = (r_state == S_CLEAR);
    o_clr_addr      = r_clr_addr;
    o_out_valid     = r_out_valid;
    o_fill_cnt      = r_fill_cnt;
    o_drop_cnt      = r_drop_cnt;
    o_state         = r_state;
  end

endmodule

// File: tb/tb_sma_window_ctrl.sv
// Testbench for sma_window_ctrl: table of window selects plus hand-written
// sequences for drops, disable, saturation and asynchronous reset.
module tb_sma_window_ctrl;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_enable;
  logic        i_data_valid;
  logic [31:0] i_data;
  logic [31:0] i_window_sel;
  logic        i_drop_clr;

  logic        o_update_strobe;
  logic [31:0] o_sma_data;
  logic [31:0] o_window_sel;
  logic        o_sum_clr;
  logic        o_clr_we;
  logic [14:0] o_clr_addr;
  logic        o_out_valid;
  logic [15:0] o_fill_cnt;
  logic [15:0] o_drop_cnt;
  logic [1:0]  o_state;

  // Second instance with a narrow drop counter, used to reach saturation quickly
  logic        s_update_strobe;
  logic [31:0] s_sma_data;
  logic [31:0] s_window_sel;
  logic        s_sum_clr;
  logic        s_clr_we;
  logic [14:0] s_clr_addr;
  logic        s_out_valid;
  logic [15:0] s_fill_cnt;
  logic [3:0]  s_drop_cnt;
  logic [1:0]  s_state;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] sb_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  sma_window_ctrl u_dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_data_valid(i_data_valid),
    .i_data(i_data), .i_window_sel(i_window_sel), .i_drop_clr(i_drop_clr),
    .o_update_strobe(o_update_strobe), .o_sma_data(o_sma_data), .o_window_sel(o_window_sel),
    .o_sum_clr(o_sum_clr), .o_clr_we(o_clr_we), .o_clr_addr(o_clr_addr),
    .o_out_valid(o_out_valid), .o_fill_cnt(o_fill_cnt), .o_drop_cnt(o_drop_cnt),
    .o_state(o_state)
  );

  sma_window_ctrl #(.MAX_SEL(15), .ADDR_W(15), .DROP_W(4)) u_dut_sat (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_data_valid(i_data_valid),
    .i_data(i_data), .i_window_sel(i_window_sel), .i_drop_clr(i_drop_clr),
    .o_update_strobe(s_update_strobe), .o_sma_data(s_sma_data), .o_window_sel(s_window_sel),
    .o_sum_clr(s_sum_clr), .o_clr_we(s_clr_we), .o_clr_addr(s_clr_addr),
    .o_out_valid(s_out_valid), .o_fill_cnt(s_fill_cnt), .o_drop_cnt(s_drop_cnt),
    .o_state(s_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every forwarded strobe must match the oldest expected sample
  always @(negedge clk) begin
    if (i_rst_n && o_update_strobe) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got data %0h expected no strobe", o_sma_data);
      end else begin
        mon_exp = sb_q.pop_front();
        if (o_sma_data !== mon_exp) begin
          n_err++;
          $display("FAIL strobe_data: got %0h expected %0h", o_sma_data, mon_exp);
        end else begin
          $display("ok   strobe_data: %0h", o_sma_data);
        end
      end
    end
  end

  // Called on the first CLEAR cycle; walks the clear and drives n_val valids on cycles 1..n_val
  task automatic do_clear(input int n, input int n_val);
    int bad_addr  = 0;
    int bad_pulse = 0;
    int last_addr = -1;
    for (int i = 0; i < n; i++) begin
      if (o_clr_we !== 1'b1 || o_clr_addr !== 15'(i) || o_state !== 2'd1) bad_addr++;
      if (o_sum_clr !== (i == 0)) bad_pulse++;
      last_addr    = int'(o_clr_addr);
      i_data_valid = (i >= 1 && i <= n_val);
      i_data       = 32'(1000 + i);
      step();
    end
    i_data_valid = 1'b0;
    check("clr_addr_seq", 64'(bad_addr), 64'd0);
    check("sum_clr_pulse", 64'(bad_pulse), 64'd0);
    check("clr_last_addr", 64'(last_addr), 64'(n - 1));
    check("clr_to_fill", 64'(o_state), 64'd2);
    check("clr_we_off", 64'(o_clr_we), 64'd0);
    check("fill_cnt_zero", 64'(o_fill_cnt), 64'd0);
  endtask

  // Called in FILL; forwards n samples and expects RUN with the last one
  task automatic fill(input int n, input int base);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      i_data_valid = 1'b1;
      i_data       = 32'(base + k);
      sb_q.push_back(32'(base + k));
      step();
      if (o_update_strobe !== 1'b1) bad++;
      if (k < n - 1 && (o_state !== 2'd2 || o_out_valid !== 1'b0 || o_fill_cnt !== 16'(k + 1))) bad++;
    end
    i_data_valid = 1'b0;
    check("fill_progress", 64'(bad), 64'd0);
    check("run_state", 64'(o_state), 64'd3);
    check("out_valid_rise", 64'(o_out_valid), 64'd1);
    check("fill_cnt_full", 64'(o_fill_cnt), 64'(n));
  endtask

  typedef struct {
    logic [31:0] sel;
    logic [31:0] exp_sel;
    int          exp_n;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bad;
    int guard;

    vecs[0] = '{sel: 32'd0,  exp_sel: 32'd0,  exp_n: 1};
    vecs[1] = '{sel: 32'd1,  exp_sel: 32'd1,  exp_n: 2};
    vecs[2] = '{sel: 32'd4,  exp_sel: 32'd4,  exp_n: 16};
    vecs[3] = '{sel: 32'd40, exp_sel: 32'd15, exp_n: 32768};
    vecs[4] = '{sel: 32'd2,  exp_sel: 32'd2,  exp_n: 4};

    i_rst_n      = 1'b0;
    i_enable     = 1'b0;
    i_data_valid = 1'b0;
    i_data       = '0;
    i_window_sel = '0;
    i_drop_clr   = 1'b0;
    step();
    step();

    // Reset values
    check("rst_state", 64'(o_state), 64'd0);
    check("rst_strobe", 64'(o_update_strobe), 64'd0);
    check("rst_sum_clr", 64'(o_sum_clr), 64'd0);
    check("rst_clr_we", 64'(o_clr_we), 64'd0);
    check("rst_out_valid", 64'(o_out_valid), 64'd0);
    check("rst_window_sel", 64'(o_window_sel), 64'd0);
    check("rst_drop_cnt", 64'(o_drop_cnt), 64'd0);

    // Test 1: enable with sel 3 -> 8-cycle clear
    i_rst_n      = 1'b1;
    step();
    i_enable     = 1'b1;
    i_window_sel = 32'd3;
    step();
    check("t1_window_sel", 64'(o_window_sel), 64'd3);
    do_clear(8, 0);

    // Test 2: 8 samples fill the window, then RUN forwards with fill_cnt held
    fill(8, 1);
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      i_data_valid = 1'b1;
      i_data       = 32'(50 + k);
      sb_q.push_back(32'(50 + k));
      step();
      if (o_state !== 2'd3 || o_fill_cnt !== 16'd8 || o_out_valid !== 1'b1) bad++;
    end
    i_data_valid = 1'b0;
    check("run_hold", 64'(bad), 64'd0);

    // Test 3: window change with coincident valid, then 3 valids during clear
    i_window_sel = 32'd5;
    i_data_valid = 1'b1;
    i_data       = 32'd99;
    step();
    i_data_valid = 1'b0;
    check("t3_drop_change", 64'(o_drop_cnt), 64'd1);
    check("t3_out_valid", 64'(o_out_valid), 64'd0);
    check("t3_state", 64'(o_state), 64'd1);
    check("t3_window_sel", 64'(o_window_sel), 64'd5);
    do_clear(32, 3);
    check("t3_drop_clear", 64'(o_drop_cnt), 64'd4);

    // Table: window selects including pass-through and clamping
    for (int r = 0; r < 5; r++) begin
      i_window_sel = vecs[r].sel;
      step();
      check("tbl_window_sel", 64'(o_window_sel), 64'(vecs[r].exp_sel));
      check("tbl_clear_entry", 64'(o_state), 64'd1);
      do_clear(vecs[r].exp_n, 0);
      if (vecs[r].exp_n <= 64) fill(vecs[r].exp_n, 100 * (r + 1));
    end

    // Test 5: disable mid-clear, then re-enable with a sample (dropped in IDLE)
    i_window_sel = 32'd6;
    step();
    for (int i = 0; i < 10; i++) step();
    check("t5_addr10", 64'(o_clr_addr), 64'd10);
    i_enable     = 1'b0;
    i_data_valid = 1'b1;
    i_data       = 32'd77;
    step();
    i_data_valid = 1'b0;
    check("t5_idle", 64'(o_state), 64'd0);
    check("t5_clr_we", 64'(o_clr_we), 64'd0);
    check("t5_out_valid", 64'(o_out_valid), 64'd0);
    check("t5_no_drop_disabled", 64'(o_drop_cnt), 64'd4);
    i_enable     = 1'b1;
    i_data_valid = 1'b1;
    step();
    i_data_valid = 1'b0;
    check("t5_drop_idle", 64'(o_drop_cnt), 64'd5);
    do_clear(64, 0);

    // Test 6: saturation (narrow instance), clear-with-drop, then async reset mid-FILL
    i_window_sel = 32'd7;
    i_data_valid = 1'b1;
    for (int j = 0; j < 20; j++) step();
    i_data_valid = 1'b0;
    check("t6_drop_main", 64'(o_drop_cnt), 64'd25);
    check("t6_drop_sat", 64'(s_drop_cnt), 64'd15);
    i_drop_clr   = 1'b1;
    i_data_valid = 1'b1;
    step();
    check("t6_clr_with_drop", 64'(o_drop_cnt), 64'd1);
    check("t6_clr_with_drop_sat", 64'(s_drop_cnt), 64'd1);
    i_data_valid = 1'b0;
    step();
    i_drop_clr   = 1'b0;
    check("t6_clr_only", 64'(o_drop_cnt), 64'd0);

    guard = 0;
    while (o_state !== 2'd2 && guard < 300) begin
      step();
      guard++;
    end
    check("t6_reach_fill", 64'(o_state), 64'd2);
    for (int k = 0; k < 2; k++) begin
      i_data_valid = 1'b1;
      i_data       = 32'(500 + k);
      sb_q.push_back(32'(500 + k));
      step();
    end
    i_data_valid = 1'b0;
    step();
    check("t6_fill_cnt2", 64'(o_fill_cnt), 64'd2);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t6_arst_state", 64'(o_state), 64'd0);
    check("t6_arst_fill_cnt", 64'(o_fill_cnt), 64'd0);
    check("t6_arst_window_sel", 64'(o_window_sel), 64'd0);
    check("t6_arst_sma_data", 64'(o_sma_data), 64'd0);
    check("t6_arst_misc", 64'({o_update_strobe, o_sum_clr, o_clr_we, o_out_valid}), 64'd0);
    check("t6_arst_clr_addr", 64'(o_clr_addr), 64'd0);
    i_enable = 1'b0;
    step();
    i_rst_n = 1'b1;
    step();
    check("t6_post_rst_idle", 64'(o_state), 64'd0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
